// File: rtl/writeback_control.sv
// Write-back stage: accepts one retiring instruction per handshake, waits for load
// data when needed, and issues a single registered register-file write per instruction.
module writeback_control #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [REG_AW-1:0] rd,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   immediate,
  input  logic [XLEN-1:0]   pc,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              flush,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              busy,
  output logic              retire
);

  localparam int OFF_W = (XLEN == 64) ? 3 : 2;
  localparam logic [OFF_W-1:0] HALF_MASK = ~OFF_W'(1'b1);
  localparam logic [OFF_W-1:0] WORD_MASK = ~OFF_W'(2'b11);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic               busy_s;
  logic [2:0]         funct3_r;
  logic [REG_AW-1:0]  rd_r;
  logic [OFF_W-1:0]   offset_r;

  function automatic logic writes_rd(input logic [6:0] opc);
    logic w;
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_AUIPC, OPC_LUI, OPC_JAL, OPC_JALR, OPC_LOAD: w = 1'b1;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic logic [XLEN-1:0] select_value(
    input logic [6:0]      opc,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] imm,
    input logic [XLEN-1:0] pcv
  );
    logic [XLEN-1:0] v;
    case (opc)
      OPC_LUI:           v = imm;
      OPC_JAL, OPC_JALR: v = pcv + XLEN'(3'd4);
      default:           v = alu;
    endcase
    return v;
  endfunction

  // Lane-extract relative to the effective-address offset; extension by casting a signed slice.
  function automatic logic [XLEN-1:0] extract_load(
    input logic [XLEN-1:0]  data,
    input logic [2:0]       f3,
    input logic [OFF_W-1:0] off
  );
    logic [XLEN-1:0] byte_s;
    logic [XLEN-1:0] half_s;
    logic [XLEN-1:0] word_s;
    logic [XLEN-1:0] res;
    byte_s = data >> {off, 3'b000};
    half_s = data >> {off & HALF_MASK, 3'b000};
    word_s = data >> {off & WORD_MASK, 3'b000};
    case (f3)
      3'b000: res = XLEN'($signed(byte_s[7:0]));
      3'b100: res = XLEN'(byte_s[7:0]);
      3'b001: res = XLEN'($signed(half_s[15:0]));
      3'b101: res = XLEN'(half_s[15:0]);
      3'b010: res = XLEN'($signed(word_s[31:0]));
      3'b110: begin
        if (XLEN == 64) begin
          res = XLEN'(word_s[31:0]);
        end else begin
          res = data;
        end
      end
      3'b011:  res = data;
      default: res = data;
    endcase
    return res;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; flush outranks mem_rvalid while waiting
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (opcode == OPC_LOAD) begin
            state_next_s = ST_WAIT_MEM;
          end else begin
            state_next_s = ST_WRITE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT_MEM: begin
        if (flush) begin
          state_next_s = ST_IDLE;
        end else if (mem_rvalid) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_WAIT_MEM;
        end
      end
      ST_WRITE: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy_s = 1'b0;
    if (state_r != ST_IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  assign busy     = busy_s;
  assign in_ready = !busy_s;

  // Only the fields needed to finish a load are kept; other results are resolved at accept time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      funct3_r <= 3'b000;
      rd_r     <= {REG_AW{1'b0}};
      offset_r <= {OFF_W{1'b0}};
    end else if (state_r == ST_IDLE && in_valid) begin
      funct3_r <= funct3;
      rd_r     <= rd;
      offset_r <= alu_result[OFF_W-1:0];
    end
  end

  // Registered write port: loaded on entry to WRITE so strobe and data are valid during WRITE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= {REG_AW{1'b0}};
      rf_wdata <= {XLEN{1'b0}};
      retire   <= 1'b0;
    end else begin
      rf_we  <= 1'b0;
      retire <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid && opcode != OPC_LOAD) begin
            retire <= 1'b1;
            if (writes_rd(opcode) && rd != {REG_AW{1'b0}}) begin
              rf_we    <= 1'b1;
              rf_waddr <= rd;
              rf_wdata <= select_value(opcode, alu_result, immediate, pc);
            end
          end
        end
        ST_WAIT_MEM: begin
          if (!flush && mem_rvalid) begin
            retire <= 1'b1;
            if (rd_r != {REG_AW{1'b0}}) begin
              rf_we    <= 1'b1;
              rf_waddr <= rd_r;
              rf_wdata <= extract_load(mem_rdata, funct3_r, offset_r);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_control.sv
// Directed bench for writeback_control: a 32-bit instance for the main flows and a
// 64-bit instance for doubleword-lane loads.
module tb_writeback_control;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_mem_rvalid, a_flush;
  logic [6:0]  a_opcode;
  logic [2:0]  a_funct3;
  logic [4:0]  a_rd, a_rf_waddr;
  logic [31:0] a_alu, a_imm, a_pc, a_mem_rdata, a_rf_wdata;
  logic        a_rf_we, a_busy, a_retire;

  logic        b_in_valid, b_in_ready, b_mem_rvalid, b_flush;
  logic [6:0]  b_opcode;
  logic [2:0]  b_funct3;
  logic [4:0]  b_rd, b_rf_waddr;
  logic [63:0] b_alu, b_imm, b_pc, b_mem_rdata, b_rf_wdata;
  logic        b_rf_we, b_busy, b_retire;

  writeback_control #(.XLEN(32), .REG_AW(5)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .opcode(a_opcode), .funct3(a_funct3), .rd(a_rd), .alu_result(a_alu),
    .immediate(a_imm), .pc(a_pc), .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata),
    .flush(a_flush), .rf_we(a_rf_we), .rf_waddr(a_rf_waddr), .rf_wdata(a_rf_wdata),
    .busy(a_busy), .retire(a_retire)
  );

  writeback_control #(.XLEN(64), .REG_AW(5)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .opcode(b_opcode), .funct3(b_funct3), .rd(b_rd), .alu_result(b_alu),
    .immediate(b_imm), .pc(b_pc), .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata),
    .flush(b_flush), .rf_we(b_rf_we), .rf_waddr(b_rf_waddr), .rf_wdata(b_rf_wdata),
    .busy(b_busy), .retire(b_retire)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_a(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                         input logic [31:0] alu, input logic [31:0] imm, input logic [31:0] p);
    a_opcode = op; a_funct3 = f3; a_rd = r; a_alu = alu; a_imm = imm; a_pc = p;
    a_in_valid = 1'b1;
  endtask

  task automatic offer_b(input logic [2:0] f3, input logic [4:0] r, input logic [63:0] alu);
    b_opcode = 7'b0000011; b_funct3 = f3; b_rd = r; b_alu = alu;
    b_in_valid = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    a_in_valid = 1'b0; a_mem_rvalid = 1'b0; a_flush = 1'b0; a_opcode = 7'd0; a_funct3 = 3'd0;
    a_rd = 5'd0; a_alu = 32'd0; a_imm = 32'd0; a_pc = 32'd0; a_mem_rdata = 32'd0;
    b_in_valid = 1'b0; b_mem_rvalid = 1'b0; b_flush = 1'b0; b_opcode = 7'd0; b_funct3 = 3'd0;
    b_rd = 5'd0; b_alu = 64'd0; b_imm = 64'd0; b_pc = 64'd0; b_mem_rdata = 64'd0;

    #3;
    check("rst_we", {63'd0, a_rf_we}, 64'd0);
    check("rst_waddr", {59'd0, a_rf_waddr}, 64'd0);
    check("rst_wdata", {32'd0, a_rf_wdata}, 64'd0);
    check("rst_busy", {63'd0, a_busy}, 64'd0);
    check("rst_retire", {63'd0, a_retire}, 64'd0);
    check("rst_ready", {63'd0, a_in_ready}, 64'd1);
    check("rst_b_ready", {63'd0, b_in_ready}, 64'd1);
    #4 reset_n = 1'b1;
    tick();

    // ADDI x5
    offer_a(7'b0010011, 3'b000, 5'd5, 32'h0000_0010, 32'd0, 32'd0);
    tick(); a_in_valid = 1'b0;
    check("addi_we", {63'd0, a_rf_we}, 64'd1);
    check("addi_waddr", {59'd0, a_rf_waddr}, 64'd5);
    check("addi_wdata", {32'd0, a_rf_wdata}, 64'h10);
    check("addi_retire", {63'd0, a_retire}, 64'd1);
    check("addi_ready", {63'd0, a_in_ready}, 64'd0);
    tick();
    check("addi_we_drop", {63'd0, a_rf_we}, 64'd0);
    check("addi_retire_drop", {63'd0, a_retire}, 64'd0);
    check("addi_ready_back", {63'd0, a_in_ready}, 64'd1);

    // JAL x1 wrap
    offer_a(7'b1101111, 3'b000, 5'd1, 32'd0, 32'd0, 32'hFFFF_FFFC);
    tick(); a_in_valid = 1'b0;
    check("jal_we", {63'd0, a_rf_we}, 64'd1);
    check("jal_waddr", {59'd0, a_rf_waddr}, 64'd1);
    check("jal_wdata", {32'd0, a_rf_wdata}, 64'd0);
    tick();

    // LUI x0: retire only, write port holds
    offer_a(7'b0110111, 3'b000, 5'd0, 32'd0, 32'h1234_5000, 32'd0);
    tick(); a_in_valid = 1'b0;
    check("lui_x0_we", {63'd0, a_rf_we}, 64'd0);
    check("lui_x0_retire", {63'd0, a_retire}, 64'd1);
    check("lui_x0_hold", {32'd0, a_rf_wdata}, 64'd0);
    tick();

    // BRANCH: retire only
    offer_a(7'b1100011, 3'b000, 5'd4, 32'h77, 32'd0, 32'd0);
    tick(); a_in_valid = 1'b0;
    check("br_we", {63'd0, a_rf_we}, 64'd0);
    check("br_retire", {63'd0, a_retire}, 64'd1);
    check("br_waddr_hold", {59'd0, a_rf_waddr}, 64'd1);
    tick();

    // LB offset 3, data three cycles later
    a_mem_rdata = 32'h80AA_BBCC;
    offer_a(7'b0000011, 3'b000, 5'd7, 32'h0000_1003, 32'd0, 32'd0);
    tick(); a_in_valid = 1'b0;
    check("lb_busy", {63'd0, a_busy}, 64'd1);
    check("lb_retire_early", {63'd0, a_retire}, 64'd0);
    tick();
    tick();
    check("lb_we_early", {63'd0, a_rf_we}, 64'd0);
    a_mem_rvalid = 1'b1;
    tick(); a_mem_rvalid = 1'b0;
    check("lb_we", {63'd0, a_rf_we}, 64'd1);
    check("lb_waddr", {59'd0, a_rf_waddr}, 64'd7);
    check("lb_wdata", {32'd0, a_rf_wdata}, 64'hFFFF_FF80);
    check("lb_retire", {63'd0, a_retire}, 64'd1);
    tick();
    check("lb_we_once", {63'd0, a_rf_we}, 64'd0);
    check("lb_ready", {63'd0, a_in_ready}, 64'd1);

    // LBU offset 3
    offer_a(7'b0000011, 3'b100, 5'd8, 32'h0000_0003, 32'd0, 32'd0);
    tick(); a_in_valid = 1'b0; a_mem_rvalid = 1'b1;
    tick(); a_mem_rvalid = 1'b0;
    check("lbu_wdata", {32'd0, a_rf_wdata}, 64'h0000_0080);
    tick();

    // LH offset 2
    offer_a(7'b0000011, 3'b001, 5'd10, 32'h0000_0002, 32'd0, 32'd0);
    tick(); a_in_valid = 1'b0; a_mem_rvalid = 1'b1;
    tick(); a_mem_rvalid = 1'b0;
    check("lh_wdata", {32'd0, a_rf_wdata}, 64'hFFFF_80AA);
    tick();

    // flush beats mem_rvalid
    offer_a(7'b0000011, 3'b010, 5'd11, 32'h0000_0000, 32'd0, 32'd0);
    tick(); a_in_valid = 1'b0; a_flush = 1'b1; a_mem_rvalid = 1'b1;
    tick(); a_flush = 1'b0; a_mem_rvalid = 1'b0;
    check("flush_we", {63'd0, a_rf_we}, 64'd0);
    check("flush_retire", {63'd0, a_retire}, 64'd0);
    check("flush_busy", {63'd0, a_busy}, 64'd0);
    check("flush_wdata_hold", {32'd0, a_rf_wdata}, 64'hFFFF_80AA);

    // stray mem_rvalid in IDLE
    a_mem_rvalid = 1'b1;
    tick(); a_mem_rvalid = 1'b0;
    check("stray_we", {63'd0, a_rf_we}, 64'd0);
    check("stray_retire", {63'd0, a_retire}, 64'd0);
    check("stray_busy", {63'd0, a_busy}, 64'd0);

    // flush in IDLE does not block a non-load
    a_flush = 1'b1;
    offer_a(7'b0110011, 3'b000, 5'd12, 32'h0000_0055, 32'd0, 32'd0);
    tick(); a_in_valid = 1'b0; a_flush = 1'b0;
    check("idle_flush_we", {63'd0, a_rf_we}, 64'd1);
    check("idle_flush_wdata", {32'd0, a_rf_wdata}, 64'h55);
    tick();

    // reset while waiting for a load
    offer_a(7'b0000011, 3'b010, 5'd9, 32'h0000_0000, 32'd0, 32'd0);
    tick(); a_in_valid = 1'b0;
    check("wait_busy", {63'd0, a_busy}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_waddr", {59'd0, a_rf_waddr}, 64'd0);
    check("mid_rst_wdata", {32'd0, a_rf_wdata}, 64'd0);
    check("mid_rst_busy", {63'd0, a_busy}, 64'd0);
    check("mid_rst_ready", {63'd0, a_in_ready}, 64'd1);
    #2 reset_n = 1'b1;
    a_mem_rvalid = 1'b1;
    tick(); a_mem_rvalid = 1'b0;
    check("post_rst_we", {63'd0, a_rf_we}, 64'd0);
    check("post_rst_retire", {63'd0, a_retire}, 64'd0);
    check("post_rst_busy", {63'd0, a_busy}, 64'd0);

    // XLEN=64 word and doubleword lanes
    b_mem_rdata = 64'h8000_0001_0000_0000;
    offer_b(3'b010, 5'd3, 64'h0000_0000_0000_0004);
    tick(); b_in_valid = 1'b0; b_mem_rvalid = 1'b1;
    tick(); b_mem_rvalid = 1'b0;
    check("lw64_we", {63'd0, b_rf_we}, 64'd1);
    check("lw64_waddr", {59'd0, b_rf_waddr}, 64'd3);
    check("lw64_wdata", b_rf_wdata, 64'hFFFF_FFFF_8000_0001);
    tick();
    offer_b(3'b110, 5'd3, 64'h0000_0000_0000_0004);
    tick(); b_in_valid = 1'b0; b_mem_rvalid = 1'b1;
    tick(); b_mem_rvalid = 1'b0;
    check("lwu64_wdata", b_rf_wdata, 64'h0000_0000_8000_0001);
    tick();
    offer_b(3'b011, 5'd6, 64'h0000_0000_0000_0000);
    tick(); b_in_valid = 1'b0; b_mem_rvalid = 1'b1;
    tick(); b_mem_rvalid = 1'b0;
    check("ld64_wdata", b_rf_wdata, 64'h8000_0001_0000_0000);
    check("ld64_waddr", {59'd0, b_rf_waddr}, 64'd6);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
